// File: rtl/t02_mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of the Wishbone manager, with watchdog.
// Define T02_MEM_ARB_RR_EN for round-robin tie-break; otherwise D has fixed priority over I.
module t02_mem_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              i_ren,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_sel,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_sel,
    output logic              mem_ren,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy,
    output logic              err,
    output logic              grant_d
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          sel_q;
    logic                write_q;
    logic                grant_d_q;
    logic                err_q;
    logic [CntW-1:0]     cnt_q;
    logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;

    logic d_req, pick_d, grant, in_xfer, wd_hit, rd_capture;

    assign d_req = d_ren | d_wen;
`ifdef T02_MEM_ARB_RR_EN
    // On a tie the port not granted last wins; grant_d_q resets to 0 so D takes the first tie.
    assign pick_d = d_req & (~i_ren | ~grant_d_q);
`else
    assign pick_d = d_req;
`endif
    assign grant      = (state_q == StIdle) & en & (d_req | i_ren);
    assign in_xfer    = (state_q == StIssue) | (state_q == StWait);
    assign wd_hit     = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES));
    assign rd_capture = (state_q == StWait) & ~mem_busy & ~wd_hit & ~write_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = StIssue;
            StIssue: begin
                if (wd_hit)        state_d = StDone;
                else if (mem_busy) state_d = StWait;
            end
            StWait: begin
                if (wd_hit || !mem_busy) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_ren = (state_q == StIssue) & ~write_q;
        mem_wen = (state_q == StIssue) & write_q;
        i_ack   = (state_q == StDone) & ~grant_d_q;
        d_ack   = (state_q == StDone) & grant_d_q;
        err     = (state_q == StDone) & err_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            write_q   <= 1'b0;
            grant_d_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            err_q <= in_xfer & wd_hit;
            if (grant) begin
                addr_q    <= pick_d ? d_addr : i_addr;
                wdata_q   <= pick_d ? d_wdata : '0;
                sel_q     <= pick_d ? d_sel : 4'hF;
                write_q   <= pick_d & d_wen;
                grant_d_q <= pick_d;
                cnt_q     <= '0;
            end else if (in_xfer && cnt_q != {CntW{1'b1}}) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // A watchdog abort returns zero data to the winner.
            if (in_xfer && wd_hit) begin
                if (grant_d_q) d_rdata_q <= '0;
                else           i_rdata_q <= '0;
            end else if (rd_capture) begin
                if (grant_d_q) d_rdata_q <= mem_rdata;
                else           i_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_sel   = sel_q;
    assign grant_d   = grant_d_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_t02_mem_arbiter.sv
// Directed bench for t02_mem_arbiter; the manager's BUSY handshake is driven cycle by cycle.
module tb_t02_mem_arbiter;

    logic        clk = 1'b0;
    logic        nrst, en;
    logic        i_ren, d_ren, d_wen, i_ack, d_ack;
    logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata;
    logic [3:0]  d_sel, mem_sel;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ren, mem_wen, mem_busy, err, grant_d;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_d_rdata;
    logic [31:0] exp_i_rdata;
    logic        exp_order [4];

    t02_mem_arbiter #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .i_ren    (i_ren),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ack    (i_ack),
        .d_ren    (d_ren),
        .d_wen    (d_wen),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_sel    (d_sel),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_sel  (mem_sel),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .mem_rdata(mem_rdata),
        .mem_busy (mem_busy),
        .err      (err),
        .grant_d  (grant_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with requests applied; returns in the IDLE cycle after DONE.
    task automatic run_txn(input string tag, input logic exp_d, input logic exp_w,
                           input logic [31:0] exp_addr, input logic [3:0] exp_sel,
                           input logic [31:0] exp_wdata, input logic [31:0] rd,
                           input logic drop);
        tick();
        check({tag, " grant_d"}, {31'd0, grant_d}, {31'd0, exp_d});
        check({tag, " strobes"}, {30'd0, mem_wen, mem_ren}, exp_w ? 32'd2 : 32'd1);
        check({tag, " addr"}, mem_addr, exp_addr);
        check({tag, " sel"}, {28'd0, mem_sel}, {28'd0, exp_sel});
        check({tag, " wdata"}, mem_wdata, exp_wdata);
        if (drop) begin
            if (exp_d) begin d_ren = 1'b0; d_wen = 1'b0; end
            else       i_ren = 1'b0;
        end
        mem_busy = 1'b0;
        tick();
        mem_busy = 1'b1;
        tick();
        check({tag, " strobes_wait"}, {30'd0, mem_wen, mem_ren}, 32'd0);
        tick();
        mem_busy  = 1'b0;
        mem_rdata = rd;
        tick();
        check({tag, " ack"}, {30'd0, d_ack, i_ack}, exp_d ? 32'd2 : 32'd1);
        check({tag, " err"}, {31'd0, err}, 32'd0);
        if (!exp_w) begin
            if (exp_d) exp_d_rdata = rd;
            else       exp_i_rdata = rd;
        end
        tick();
        check({tag, " d_rdata"}, d_rdata, exp_d_rdata);
        check({tag, " i_rdata"}, i_rdata, exp_i_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int seen;
        nrst = 1'b0; en = 1'b1;
        i_ren = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_sel = '0;
        mem_rdata = '0; mem_busy = 1'b0;
        exp_d_rdata = '0; exp_i_rdata = '0;
`ifdef T02_MEM_ARB_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        tick(); tick();
        check("rst strobes", {30'd0, mem_wen, mem_ren}, 32'd0);
        check("rst acks", {29'd0, err, d_ack, i_ack}, 32'd0);
        check("rst grant_d", {31'd0, grant_d}, 32'd0);
        check("rst addr", mem_addr, 32'd0);
        nrst = 1'b1;
        tick();

        // Single fetch: busy high in cycles 2..5, low from cycle 6, ack in cycle 7.
        i_ren = 1'b1; i_addr = 32'h3300_0000;
        tick();
        check("fetch c1 mem_ren", {31'd0, mem_ren}, 32'd1);
        check("fetch c1 addr", mem_addr, 32'h3300_0000);
        i_ren = 1'b0;
        tick();
        mem_busy = 1'b1;
        check("fetch c2 mem_ren", {31'd0, mem_ren}, 32'd1);
        tick();
        check("fetch c3 mem_ren", {31'd0, mem_ren}, 32'd0);
        tick(); tick(); tick();
        mem_busy = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        check("fetch c6 ack", {31'd0, i_ack}, 32'd0);
        tick();
        check("fetch c7 ack", {30'd0, d_ack, i_ack}, 32'd1);
        check("fetch c7 rdata", i_rdata, 32'hDEAD_BEEF);
        check("fetch c7 err", {31'd0, err}, 32'd0);
        exp_i_rdata = 32'hDEAD_BEEF;
        tick();
        check("fetch c8 ack", {31'd0, i_ack}, 32'd0);

        // Fairness: both ports hold read requests across four transactions.
        i_ren = 1'b1; i_addr = 32'h100; d_ren = 1'b1; d_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            run_txn($sformatf("fair%0d", k), exp_order[k], 1'b0,
                    exp_order[k] ? 32'h200 : 32'h100, exp_order[k] ? 4'h0 : 4'hF,
                    32'h0, 32'h1000 + k, 1'b0);
        end
        i_ren = 1'b0; d_ren = 1'b0;
        tick();

        // Simultaneous I read and D write: D first, then I.
        i_ren = 1'b1; i_addr = 32'h44;
        d_wen = 1'b1; d_addr = 32'h10; d_wdata = 32'h55; d_sel = 4'b0011;
        run_txn("sim_d", 1'b1, 1'b1, 32'h10, 4'b0011, 32'h55, 32'hBAD0_0001, 1'b1);
        run_txn("sim_i", 1'b0, 1'b0, 32'h44, 4'hF, 32'h0, 32'h0000_4444, 1'b1);

        // Watchdog: busy stuck high, DONE at ISSUE entry + 8 + 1.
        d_ren = 1'b1; d_addr = 32'h300; d_sel = 4'hF;
        tick();
        check("wd c1 mem_ren", {31'd0, mem_ren}, 32'd1);
        d_ren = 1'b0; mem_busy = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("wd c9 ack", {29'd0, err, d_ack, i_ack}, 32'd0);
        tick();
        check("wd c10 ack_err", {29'd0, err, d_ack, i_ack}, 32'd6);
        check("wd c10 d_rdata", d_rdata, 32'd0);
        exp_d_rdata = '0;
        tick();
        check("wd c11 idle", {28'd0, mem_ren, err, d_ack, i_ack}, 32'd0);
        mem_busy = 1'b0;
        tick();

        // en gating, then en dropped during WAIT.
        en = 1'b0; i_ren = 1'b1; i_addr = 32'h400;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (mem_ren || mem_wen) seen++;
        end
        check("en_low no strobe", seen, 32'd0);
        en = 1'b1;
        tick();
        check("en_high issue", {31'd0, mem_ren}, 32'd1);
        i_ren = 1'b0;
        tick();
        mem_busy = 1'b1;
        tick();
        en = 1'b0;
        tick();
        mem_busy = 1'b0; mem_rdata = 32'hCAFE_0001;
        tick();
        check("en_drop ack", {30'd0, d_ack, i_ack}, 32'd1);
        check("en_drop rdata", i_rdata, 32'hCAFE_0001);
        en = 1'b1;
        tick();

        // Asynchronous reset in the middle of WAIT.
        i_ren = 1'b1; i_addr = 32'h500;
        tick();
        i_ren = 1'b0;
        tick();
        mem_busy = 1'b1;
        tick(); tick(); tick();
        nrst = 1'b0;
        #1;
        check("rstw strobes", {28'd0, mem_ren, mem_wen, i_ack, d_ack}, 32'd0);
        check("rstw i_rdata", i_rdata, 32'd0);
        check("rstw addr", mem_addr, 32'd0);
        check("rstw sel", {28'd0, mem_sel}, 32'd0);
        exp_i_rdata = '0; exp_d_rdata = '0;
        tick();
        nrst = 1'b1; mem_busy = 1'b0;
        i_ren = 1'b1; i_addr = 32'h600;
        run_txn("rst_next", 1'b0, 1'b0, 32'h600, 4'hF, 32'h0, 32'h0000_0077, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
